// File: rtl/dm_port_arbiter_if.sv
// Bundle of the core (C), DMA (D), response and memory-side signals of the data-memory port arbiter.
// The arbiter uses the slave modport; requesters and memory use the master modport.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 16
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd2
`endif
`ifndef DM_OP_UB
`define DM_OP_UB 3'd4
`endif

interface dm_port_arbiter_if #(
  parameter int ADDR_W = `DM_ADDR_BIT,
  parameter int OP_W   = `DM_OP_BIT
);
  logic              c_req;
  logic [OP_W-1:0]   c_op;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              c_ack;
  logic              d_req;
  logic [OP_W-1:0]   d_op;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [OP_W-1:0]   mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;

  modport slave (
    input  c_req, c_op, c_we, c_addr, c_wdata,
    input  d_req, d_op, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output c_ack, d_ack, rsp_data, busy,
    output mem_en, mem_we, mem_op, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_op, c_we, c_addr, c_wdata,
    output d_req, d_op, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  c_ack, d_ack, rsp_data, busy,
    input  mem_en, mem_we, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between core (C) and DMA (D).
// Optional macro DM_ARB_ALIGN_CHK_EN: reject misaligned word accesses and add the align_err port.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 16
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd2
`endif
`ifndef DM_OP_UB
`define DM_OP_UB 3'd4
`endif

// state  | meaning
// IDLE   | sample requests, latch winner's command
// ACCESS | drive memory for one cycle, capture read data
// RESP   | pulse owner's ack with rsp_data valid
module dm_port_arbiter #(
  parameter int ADDR_W  = `DM_ADDR_BIT,
  parameter int OP_W    = `DM_OP_BIT,
  parameter bit C_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  dm_port_arbiter_if.slave bus
`ifdef DM_ARB_ALIGN_CHK_EN
  ,
  output logic align_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              own_d_q;
  logic              ptr_c_q;
  logic [OP_W-1:0]   cmd_op_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [31:0]       cmd_wdata_q;

  logic              any_req, grant_c, grant_d, misalign;
  logic [OP_W-1:0]   win_op;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;

  assign any_req = bus.c_req | bus.d_req;
  assign grant_c = bus.c_req & (~bus.d_req | ptr_c_q);
  assign grant_d = bus.d_req & ~grant_c;

  always_comb begin
    win_op    = bus.c_op;
    win_we    = bus.c_we;
    win_addr  = bus.c_addr;
    win_wdata = bus.c_wdata;
    if (grant_d) begin
      win_op    = bus.d_op;
      win_we    = bus.d_we;
      win_addr  = bus.d_addr;
      win_wdata = bus.d_wdata;
    end
  end

`ifdef DM_ARB_ALIGN_CHK_EN
  logic aerr_q;
  assign misalign  = (win_op == OP_W'(`DM_OP_WD)) && (win_addr[1:0] != 2'b00);
  assign align_err = (state_q == RESP) && aerr_q;
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_op    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.c_ack     = 1'b0;
    bus.d_ack     = 1'b0;
    bus.busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) state_d = misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = cmd_we_q;
        bus.mem_op    = cmd_op_q;
        bus.mem_addr  = cmd_addr_q;
        bus.mem_wdata = cmd_wdata_q;
        state_d       = RESP;
      end
      RESP: begin
        bus.c_ack = ~own_d_q;
        bus.d_ack = own_d_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer always ends up on the requester that did not win this grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_d_q      <= 1'b0;
      ptr_c_q      <= C_FIRST;
      cmd_op_q     <= '0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      bus.rsp_data <= '0;
`ifdef DM_ARB_ALIGN_CHK_EN
      aerr_q       <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && any_req) begin
        cmd_op_q    <= win_op;
        cmd_we_q    <= win_we;
        cmd_addr_q  <= win_addr;
        cmd_wdata_q <= win_wdata;
        own_d_q     <= grant_d;
        ptr_c_q     <= grant_d;
`ifdef DM_ARB_ALIGN_CHK_EN
        aerr_q      <= misalign;
        if (misalign) bus.rsp_data <= 32'hDEAD_BEEF;
`endif
      end
      if (state_q == ACCESS) bus.rsp_data <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small byte-addressed memory model.
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 16
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_OP_WD
`define DM_OP_WD 3'd2
`endif
`ifndef DM_OP_UB
`define DM_OP_UB 3'd4
`endif

module tb_dm_port_arbiter;
  localparam logic [`DM_OP_BIT-1:0] WD = `DM_OP_WD;
  localparam logic [`DM_OP_BIT-1:0] UB = `DM_OP_UB;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  dm_port_arbiter_if bus ();

`ifdef DM_ARB_ALIGN_CHK_EN
  logic align_err;
  dm_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .align_err(align_err));
`else
  dm_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] wa;

  always_comb begin
    wa = {bus.mem_addr[7:2], 2'b00};
    if (bus.mem_op == WD)
      bus.mem_rdata = {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};
    else
      bus.mem_rdata = {24'h0, mem[bus.mem_addr[7:0]]};
  end

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      if (bus.mem_op == WD) begin
        mem[wa]        <= bus.mem_wdata[7:0];
        mem[wa + 8'd1] <= bus.mem_wdata[15:8];
        mem[wa + 8'd2] <= bus.mem_wdata[23:16];
        mem[wa + 8'd3] <= bus.mem_wdata[31:24];
      end else begin
        mem[bus.mem_addr[7:0]] <= bus.mem_wdata[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit use_d, input logic [`DM_OP_BIT-1:0] op, input logic we,
                        input logic [15:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat, output int we_cnt,
                        output int en_cnt, output int ae);
    @(negedge clk);
    if (use_d) begin
      bus.d_req = 1'b1; bus.d_op = op; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.c_req = 1'b1; bus.c_op = op; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
    end
    lat = 0; we_cnt = 0; en_cnt = 0; ae = 0;
    do begin
      @(negedge clk);
      lat++;
      we_cnt += int'(bus.mem_we);
      en_cnt += int'(bus.mem_en);
    end while (!(use_d ? bus.d_ack : bus.c_ack) && lat < 8);
`ifdef DM_ARB_ALIGN_CHK_EN
    ae = int'(align_err);
`endif
    rd = bus.rsp_data;
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  logic [31:0] rd;
  int lat, we_cnt, en_cnt, ae, nack, both, busy_cnt, ack_cnt;
  logic [3:0] seq;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'hCAFE_F00D;
    rst_n = 1'b0;
    bus.c_req = 0; bus.c_op = '0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_op = '0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_acks", {30'd0, bus.c_ack, bus.d_ack}, 32'd0);
    chk("rst_mem_en_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    rst_n = 1'b1;

    // Contention from reset: C first, then strict alternation.
    @(negedge clk);
    bus.c_req = 1; bus.c_op = WD; bus.c_we = 0; bus.c_addr = 16'h10;
    bus.d_req = 1; bus.d_op = WD; bus.d_we = 0; bus.d_addr = 16'h14;
    seq = '0; nack = 0; both = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.c_ack && bus.d_ack) both++;
      if (bus.c_ack) begin seq = {seq[2:0], 1'b1}; nack++; end
      else if (bus.d_ack) begin seq = {seq[2:0], 1'b0}; nack++; end
    end
    bus.c_req = 0; bus.d_req = 0;
    chk("rr_order", 32'(seq), 32'b1010);
    chk("rr_ack_count", 32'(nack), 32'd4);
    chk("rr_both_ack", 32'(both), 32'd0);

    access(0, WD, 1, 16'h10, 32'h1234_5678, rd, lat, we_cnt, en_cnt, ae);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_we_cycles", 32'(we_cnt), 32'd1);
    access(0, WD, 0, 16'h10, 32'h0, rd, lat, we_cnt, en_cnt, ae);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'h1234_5678);
    chk("rd_we_cycles", 32'(we_cnt), 32'd0);
    chk("resp_mem_en", 32'(bus.mem_en), 32'd0);
    chk("resp_mem_addr", 32'(bus.mem_addr), 32'd0);

    access(1, UB, 1, 16'h13, 32'h0000_00AB, rd, lat, we_cnt, en_cnt, ae);
    chk("d_wr_latency", 32'(lat), 32'd2);
    access(0, WD, 0, 16'h10, 32'h0, rd, lat, we_cnt, en_cnt, ae);
    chk("byte_merge", rd, 32'hAB34_5678);
    access(1, UB, 0, 16'h12, 32'h0, rd, lat, we_cnt, en_cnt, ae);
    chk("d_byte_rd", rd, 32'h0000_0034);

    // One-cycle request pulse, command changed after latch.
    @(negedge clk);
    bus.c_req = 1; bus.c_op = WD; bus.c_we = 0; bus.c_addr = 16'h10;
    @(negedge clk);
    bus.c_req = 0; bus.c_addr = 16'h20;
    busy_cnt = int'(bus.busy); ack_cnt = int'(bus.c_ack);
    repeat (4) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      ack_cnt  += int'(bus.c_ack);
    end
    chk("pulse_busy_cycles", 32'(busy_cnt), 32'd2);
    chk("pulse_ack_count", 32'(ack_cnt), 32'd1);
    chk("pulse_data", bus.rsp_data, 32'hAB34_5678);

    // Reset in the middle of a write access.
    @(negedge clk);
    bus.c_req = 1; bus.c_op = WD; bus.c_we = 1; bus.c_addr = 16'h20; bus.c_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_en", 32'(bus.mem_en), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rsp", bus.rsp_data, 32'd0);
    bus.c_req = 0;
    ack_cnt = 0;
    repeat (2) begin @(negedge clk); ack_cnt += int'(bus.c_ack); end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); ack_cnt += int'(bus.c_ack); end
    chk("mid_rst_no_ack", 32'(ack_cnt), 32'd0);
    access(0, WD, 0, 16'h20, 32'h0, rd, lat, we_cnt, en_cnt, ae);
    chk("mid_rst_no_commit", rd, 32'hCAFE_F00D);

    // Misaligned word read.
    access(0, WD, 0, 16'h11, 32'h0, rd, lat, we_cnt, en_cnt, ae);
`ifdef DM_ARB_ALIGN_CHK_EN
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_mem_en", 32'(en_cnt), 32'd0);
    chk("mis_align_err", 32'(ae), 32'd1);
    chk("mis_data", rd, 32'hDEAD_BEEF);
`else
    chk("mis_latency", 32'(lat), 32'd2);
    chk("mis_mem_en", 32'(en_cnt), 32'd1);
    chk("mis_data", rd, 32'hAB34_5678);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
